// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, default reply
// bytes, the sequencer state type and the decoder result bundle.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_LED_ON  = 8'hA1;
  localparam logic [7:0] CMD_LED_OFF = 8'hA2;
  localparam logic [7:0] CMD_READ    = 8'hB1;
  localparam logic [7:0] CMD_RESET   = 8'hC1;

  localparam logic [7:0] DEF_ACK_BYTE  = 8'h55;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'hEE;
  localparam logic [7:0] DEF_STAT_BASE = 8'hD0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SEND,
    ST_WAIT_TX
  } seq_state_e;

  typedef struct packed {
    logic       led_next;
    logic       soft_rst;
    logic       err_inc;
    logic [7:0] reply;
  } dec_res_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Combinational command decoder: maps the latched command byte and the
// current LED value to the LED update, soft-reset request, error increment
// and the reply byte.
module uart_cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE  = DEF_NAK_BYTE,
  parameter logic [7:0] STAT_BASE = DEF_STAT_BASE
) (
  input  logic [7:0] cmd,
  input  logic       led,
  output dec_res_t   res
);

  // Opcode table; anything unrecognised is answered with a NAK and counted.
  always_comb begin
    res.led_next = led;
    res.soft_rst = 1'b0;
    res.err_inc  = 1'b0;
    res.reply    = NAK_BYTE;
    case (cmd)
      CMD_LED_ON: begin
        res.led_next = 1'b1;
        res.reply    = ACK_BYTE;
      end
      CMD_LED_OFF: begin
        res.led_next = 1'b0;
        res.reply    = ACK_BYTE;
      end
      CMD_READ: begin
        res.reply = STAT_BASE | {7'b0, led};
      end
      CMD_RESET: begin
        res.led_next = 1'b0;
        res.soft_rst = 1'b1;
        res.reply    = ACK_BYTE;
      end
      default: begin
        res.err_inc = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: takes one received byte at a time, applies its
// effect and serialises the reply onto the shared transmitter.
// Optional build macro CMD_ECHO_EN: each command is answered with the
// command byte itself followed by the reply byte.
//
// state     | meaning
// ST_IDLE   | waiting for a received byte
// ST_DECODE | apply command effect, select reply
// ST_SEND   | wait for tx_ready, pulse tx_start
// ST_WAIT_TX| byte in flight, watch tx_ready / timeout
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE   = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE   = DEF_NAK_BYTE,
  parameter logic [7:0] STAT_BASE  = DEF_STAT_BASE,
  parameter int         TX_TIMEOUT = 4096,
  parameter int         ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             led,
  output logic             soft_rst,
  output logic             busy,
  output logic             overrun,
  output logic [ERR_W-1:0] err_cnt
);

  // Down-counter spans TX_TIMEOUT cycles of WAIT_TX; the load value doubles
  // as the marker for the first (tx_ready-ignoring) cycle after a start.
  localparam int TMO_W = ($clog2(TX_TIMEOUT) > 0) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TX_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             led_q, led_d;
  logic             soft_rst_q, soft_rst_d;
  logic             overrun_q, overrun_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             start_c;
  logic             err_bump;
  logic             err_clr;
  dec_res_t         dec;
`ifdef CMD_ECHO_EN
  logic [7:0]       reply_q, reply_d;
  logic             echo_pend_q, echo_pend_d;
`endif

  uart_cmd_decode #(
    .ACK_BYTE (ACK_BYTE),
    .NAK_BYTE (NAK_BYTE),
    .STAT_BASE(STAT_BASE)
  ) u_decode (
    .cmd(cmd_q),
    .led(led_q),
    .res(dec)
  );

  // Next-state, handshake, timeout and error-counter logic.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tx_data_d  = tx_data_q;
    led_d      = led_q;
    soft_rst_d = 1'b0;
    overrun_d  = overrun_q;
    err_cnt_d  = err_cnt_q;
    tmo_d      = tmo_q;
    start_c    = 1'b0;
    err_bump   = 1'b0;
    err_clr    = 1'b0;
`ifdef CMD_ECHO_EN
    reply_d     = reply_q;
    echo_pend_d = echo_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        led_d      = dec.led_next;
        soft_rst_d = dec.soft_rst;
        err_bump   = dec.err_inc;
        err_clr    = dec.soft_rst;
        if (dec.soft_rst) overrun_d = 1'b0;
`ifdef CMD_ECHO_EN
        tx_data_d   = cmd_q;
        reply_d     = dec.reply;
        echo_pend_d = 1'b1;
`else
        tx_data_d   = dec.reply;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          start_c = 1'b1;
          tmo_d   = TMO_LOAD;
          state_d = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tmo_q != TMO_LOAD && tx_ready) begin
`ifdef CMD_ECHO_EN
          if (echo_pend_q) begin
            tx_data_d   = reply_q;
            echo_pend_d = 1'b0;
            state_d     = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else if (tmo_q == '0) begin
          err_bump = 1'b1;
          state_d  = ST_IDLE;
`ifdef CMD_ECHO_EN
          echo_pend_d = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte offered while not idle is lost; this wins over a same-cycle clear.
    if (rx_valid && state_q != ST_IDLE) overrun_d = 1'b1;
    // NAK and timeout share one increment so the counter steps by one at most.
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_bump && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      led_q      <= 1'b0;
      soft_rst_q <= 1'b0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
      tmo_q      <= '0;
`ifdef CMD_ECHO_EN
      reply_q     <= 8'h00;
      echo_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tx_data_q  <= tx_data_d;
      led_q      <= led_d;
      soft_rst_q <= soft_rst_d;
      overrun_q  <= overrun_d;
      err_cnt_q  <= err_cnt_d;
      tmo_q      <= tmo_d;
`ifdef CMD_ECHO_EN
      reply_q     <= reply_d;
      echo_pend_q <= echo_pend_d;
`endif
    end
  end

  // The start pulse follows tx_ready in SEND so a byte leaves two cycles
  // after reception; reset suppresses it in the same cycle.
  assign tx_start = start_c & ~rst;
  assign tx_data  = tx_data_q;
  assign led      = led_q;
  assign soft_rst = soft_rst_q;
  assign busy     = (state_q != ST_IDLE);
  assign overrun  = overrun_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_uart_cmd_sequencer;

  localparam int TMO = 16;
`ifdef CMD_ECHO_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       led;
  logic       soft_rst;
  logic       busy;
  logic       overrun;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .TX_TIMEOUT(TMO),
    .ERR_W     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .led     (led),
    .soft_rst(soft_rst),
    .busy    (busy),
    .overrun (overrun),
    .err_cnt (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: command semantics, reply bytes still owed, and the
  // timing of the byte in flight expressed as cycles since its start.
  bit         m_led, m_ovr, m_soft, m_busy, m_dec, m_fly;
  int         m_err;
  int         m_start;
  logic [7:0] m_cmd;
  logic [7:0] m_q[$];

  task automatic apply_cmd(input logic [7:0] c);
    logic [7:0] r;
    case (c)
      8'hA1: begin m_led = 1'b1; r = 8'h55; end
      8'hA2: begin m_led = 1'b0; r = 8'h55; end
      8'hB1: r = 8'hD0 + {7'd0, m_led};
      8'hC1: begin m_led = 1'b0; m_err = 0; m_ovr = 1'b0; m_soft = 1'b1; r = 8'h55; end
      default: begin
        if (m_err < 255) m_err++;
        r = 8'hEE;
      end
    endcase
    if (NB == 2) m_q.push_back(c);
    m_q.push_back(r);
  endtask

  always @(posedge clk) begin
    bit was_busy;
    if (rst) begin
      m_led = 0; m_ovr = 0; m_soft = 0; m_busy = 0; m_dec = 0; m_fly = 0; m_err = 0;
      m_q.delete();
    end else begin
      was_busy = m_busy;
      m_soft   = 1'b0;
      if (m_dec) begin
        apply_cmd(m_cmd);
        m_dec = 1'b0;
      end else if (m_fly) begin
        if (cyc - m_start >= 2 && tx_ready) begin
          m_fly = 1'b0;
          if (m_q.size() == 0) m_busy = 1'b0;
        end else if (cyc - m_start == TMO) begin
          m_fly  = 1'b0;
          m_busy = 1'b0;
          m_q.delete();
          if (m_err < 255) m_err++;
        end
      end else if (m_busy && m_q.size() > 0 && tx_ready) begin
        m_fly   = 1'b1;
        m_start = cyc;
        void'(m_q.pop_front());
      end
      if (rx_valid) begin
        if (!was_busy) begin
          m_busy = 1'b1;
          m_dec  = 1'b1;
          m_cmd  = rx_data;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison plus bookkeeping for the directed checks.
  logic [7:0] last_tx = 8'h00;
  int  start_cnt = 0;
  int  soft_cnt = 0;
  int  first_start_cyc = 0;
  int  acc_cyc = 0;
  int  idle_cyc = 0;
  bit  arm = 1'b0;

  always @(negedge clk) begin
    logic e_start;
    e_start = !rst && m_busy && !m_dec && !m_fly && (m_q.size() > 0) && tx_ready;
    chk("tx_start", 32'(tx_start), 32'(e_start));
    if (e_start) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    chk("led", 32'(led), 32'(m_led));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("soft_rst", 32'(soft_rst), 32'(m_soft));
    if (tx_start === 1'b1) begin
      last_tx = tx_data;
      start_cnt++;
      if (arm) begin
        first_start_cyc = cyc;
        arm = 1'b0;
      end
    end
    if (soft_rst === 1'b1) soft_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    acc_cyc  = cyc;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    idle_cyc = cyc;
  endtask

  initial begin
    int s0;
    int sc0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // LED on: reply two cycles after reception
    arm = 1'b1;
    send_byte(8'hA1);
    wait_idle(50);
    chk("a1_latency", 32'(first_start_cyc - acc_cyc), 32'd2);
    chk("a1_reply", 32'(last_tx), 32'h55);
    chk("a1_led", 32'(led), 32'd1);

    // status readback with LED on and off
    send_byte(8'hB1);
    wait_idle(50);
    chk("b1_on_reply", 32'(last_tx), 32'hD1);
    send_byte(8'hA2);
    wait_idle(50);
    chk("a2_reply", 32'(last_tx), 32'h55);
    send_byte(8'hB1);
    wait_idle(50);
    chk("b1_off_reply", 32'(last_tx), 32'hD0);
    chk("b1_off_led", 32'(led), 32'd0);

    // unknown bytes: NAK and saturating error count
    send_byte(8'h7F);
    wait_idle(50);
    chk("nak_reply", 32'(last_tx), 32'hEE);
    chk("nak_err1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) begin
      send_byte(8'h7F);
      wait_idle(50);
    end
    chk("nak_err_sat", 32'(err_cnt), 32'hFF);

    // byte arriving while busy is dropped
    s0 = start_cnt;
    send_byte(8'hA1);
    send_byte(8'hB1);
    wait_idle(50);
    chk("ovr_starts", 32'(start_cnt - s0), 32'(NB));
    chk("ovr_reply", 32'(last_tx), 32'h55);
    chk("ovr_flag", 32'(overrun), 32'd1);

    // soft reset command, then a byte on the completion cycle is dropped
    sc0 = soft_cnt;
    send_byte(8'hC1);
    tick();
    chk("c1_soft_hi", 32'(soft_rst), 32'd1);
    chk("c1_led", 32'(led), 32'd0);
    chk("c1_err", 32'(err_cnt), 32'd0);
    chk("c1_ovr", 32'(overrun), 32'd0);
    tick();
    chk("c1_soft_lo", 32'(soft_rst), 32'd0);
    tick();
    send_byte(8'hA1);
    wait_idle(50);
    chk("c1_soft_once", 32'(soft_cnt - sc0), 32'd1);
    chk("c1_reply", 32'(last_tx), 32'h55);
    chk("late_drop_led", 32'(led), 32'd0);
    chk("late_drop_ovr", 32'(overrun), 32'd1);

    // transmitter never returns: timeout
    s0 = start_cnt;
    arm = 1'b1;
    send_byte(8'hA2);
    tick();
    tick();
    tx_ready = 1'b0;
    wait_idle(40);
    chk("tmo_cycles", 32'(idle_cyc - first_start_cyc), 32'(TMO + 1));
    chk("tmo_starts", 32'(start_cnt - s0), 32'd1);
    chk("tmo_err", 32'(err_cnt), 32'd1);
    tx_ready = 1'b1;
    tick();

    // reset while a byte is in flight
    send_byte(8'hA1);
    tick();
    tick();
    tx_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    chk("rstw_led", 32'(led), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_tx_data", 32'(tx_data), 32'h00);
    chk("rstw_ovr", 32'(overrun), 32'd0);
    chk("rstw_err", 32'(err_cnt), 32'd0);

    // reset coinciding with a would-be start
    tx_ready = 1'b0;
    send_byte(8'hB1);
    tick();
    s0 = start_cnt;
    rst = 1'b1;
    tx_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsts_no_start", 32'(start_cnt - s0), 32'd0);
    chk("rsts_busy", 32'(busy), 32'd0);

    // normal operation resumes
    send_byte(8'hA1);
    wait_idle(50);
    chk("final_reply", 32'(last_tx), 32'h55);
    chk("final_led", 32'(led), 32'd1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command controller between the UART receiver and transmitter inside the UART command top.
- Accepts one received byte at a time, decodes it, and applies the effect to the LED register, soft reset and error counter.
- Schedules the reply byte(s) onto the shared UART transmitter through a start/ready handshake.
- Only block that drives the transmitter; serialises all replies.

Parameters:
- ACK_BYTE, 8'h55, reply byte for an accepted write/reset command
- NAK_BYTE, 8'hEE, reply byte for an unknown command
- STAT_BASE, 8'hD0, base of the status reply; reply = STAT_BASE | {7'b0, led}
- TX_TIMEOUT, 4096, max cycles to wait for tx_ready to return high after a start
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter idle, can accept a byte
- tx_start  out  1  one-cycle pulse, transmitter loads tx_data
- tx_data  out  8  byte to transmit, valid while tx_start is high
- led  out  1  LED register
- soft_rst  out  1  one-cycle pulse on a 0xC1 command
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when a byte is dropped while busy, cleared by rst or 0xC1
- err_cnt  out  ERR_W  saturating count of NAKs plus TX timeouts

Behaviour:
- Reset values (synchronous, clk edge with rst=1): state IDLE, tx_start 0, tx_data 8'h00, led 0, soft_rst 0, busy 0, overrun 0, err_cnt 0. rst overrides every other event in the same cycle, including a start or an in-flight reply; nothing is resumed after reset.
- States: IDLE, DECODE, SEND, WAIT_TX.
- IDLE: on rx_valid=1, latch rx_data into cmd_q and go to DECODE.
- DECODE (one cycle): apply the effect and select the reply into reply_q, then go to SEND. Effects are visible at the output from the next cycle.
  - 0xA1: led<=1, reply ACK_BYTE.
  - 0xA2: led<=0, reply ACK_BYTE.
  - 0xB1: no state change, reply STAT_BASE|led. The reply uses the led value before any effect; B1 never changes led.
  - 0xC1: led<=0, err_cnt<=0, overrun<=0, soft_rst=1 for exactly this cycle, reply ACK_BYTE.
  - any other byte: err_cnt+1 (saturates at all-ones), reply NAK_BYTE.
- SEND: wait for tx_ready=1. In that cycle assert tx_start=1 with tx_data=reply_q, load the timeout counter, and go to WAIT_TX. tx_start is never high for two consecutive cycles.
- WAIT_TX:
  - The first cycle after the start ignores tx_ready (transmitter latency).
  - Afterwards, tx_ready=1 ends the byte: go to the next reply byte's SEND if one is pending, else IDLE.
  - Timeout counter reaches TX_TIMEOUT with no return of tx_ready: err_cnt+1 (saturating), abandon all pending bytes, go to IDLE.
- Latency: rx_valid at cycle N → DECODE at N+1 → earliest tx_start at N+2 if tx_ready=1.
- Byte arriving when state != IDLE: dropped, overrun<=1. No queueing.
- rx_valid coinciding with the WAIT_TX → IDLE transition: the byte is dropped. The decision uses the current state.
- err_cnt saturates and never wraps. When a NAK and a timeout would both increment in one cycle, the increment is still +1. This cannot happen by construction; it must still be guarded.

Optional Feature:
- Macro CMD_ECHO_EN.
- Defined: every command is answered with two bytes, cmd_q first then the reply byte, each with its own SEND/WAIT_TX pass. A timeout on the echo drops the reply byte.
- Undefined: the reply byte only; the echo path and its pending flag are not synthesised.

Decomposition:
- Package uart_cmd_pkg: command opcode constants (CMD_LED_ON 8'hA1, CMD_LED_OFF 8'hA2, CMD_READ 8'hB1, CMD_RESET 8'hC1), default ACK/NAK/STAT_BASE values, and the state enum typedef.
- Sub-module: uart_cmd_decode, purely combinational. Maps cmd_q and led to {led_next, soft_rst, err_inc, reply}.
- The FSM, timeout counter and handshake stay in uart_cmd_sequencer.

Test Plan:
- Reset, then rx byte 0xA1 with tx_ready=1 → led=1 from N+2; tx_start at N+2 with tx_data=8'h55. Echo build: 8'hA1 then 8'h55.
- 0xA1, then after the reply 0xB1 → tx_data=8'hD1. Then 0xA2, then 0xB1 → tx_data=8'hD0; led reads 0.
- Byte 0x7F → tx_data=8'hEE, err_cnt=1. Repeat 300 times with ERR_W=8 → err_cnt holds 8'hFF.
- 0xA1, then 0xB1 injected while busy → single reply 8'h55, overrun=1. Then 0xC1 → soft_rst high exactly one cycle, led=0, err_cnt=0, overrun=0, reply 8'h55.
- tx_ready held low after tx_start with TX_TIMEOUT=16 → return to IDLE after 16 cycles, err_cnt+1, no second tx_start. Also assert rst mid-WAIT_TX → all outputs at reset values on the next cycle.
